// File: rtl/alu_v2_seq_ctrl_if.sv
// Request/result bundle for the sequenced-ALU controller.
// The slave modport is the controller; the master modport is the requester,
// the ALU-side result driver and the result consumer.
interface alu_v2_seq_ctrl_if #(
  parameter int unsigned BUS_WIDTH = 8
);
  logic                 op_valid;
  logic                 op_ready;
  logic [1:0]           opcode;
  logic [4:0]           reg_en;
  logic                 f_add;
  logic                 f_load;
  logic [BUS_WIDTH-1:0] alu_result;
  logic [BUS_WIDTH-1:0] res_data;
  logic                 res_valid;
  logic                 res_ready;
  logic [7:0]           op_count;

  modport master (
    output op_valid, opcode, alu_result, res_ready,
    input  op_ready, reg_en, f_add, f_load, res_data, res_valid, op_count
  );

  modport slave (
    input  op_valid, opcode, alu_result, res_ready,
    output op_ready, reg_en, f_add, f_load, res_data, res_valid, op_count
  );
endinterface

// File: rtl/alu_v2_seq_ctrl.sv
// Sequencer for a multi-stage ALU: loads mult-stage registers a..d then op_e,
// waits one settle cycle, captures the ALU result and holds it until the
// consumer takes it. All outputs are registered from the next-state decode.
module alu_v2_seq_ctrl #(
  parameter int unsigned BUS_WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_v2_seq_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    LD_AB,
    LD_CD,
    LD_E,
    SETTLE,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_MAC    = 2'b00,
    OP_ADDI   = 2'b01,
    OP_LOADSW = 2'b10,
    OP_EONLY  = 2'b11
  } opcode_t;

  state_t               state_q,     state_d;
  opcode_t              opcode_q,    opcode_d;
  logic                 op_ready_q,  op_ready_d;
  logic [4:0]           reg_en_q,    reg_en_d;
  logic                 f_add_q,     f_add_d;
  logic                 f_load_q,    f_load_d;
  logic [BUS_WIDTH-1:0] res_data_q,  res_data_d;
  logic                 res_valid_q, res_valid_d;
  logic [7:0]           op_count_q,  op_count_d;
  logic                 accept;

  // Next-state, latched opcode/result/count, and outputs decoded from the next state
  // so that every output is a flop that already reflects the state being entered.
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    res_data_d = res_data_q;
    op_count_d = op_count_q;
    accept     = bus.op_valid && op_ready_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          opcode_d = opcode_t'(bus.opcode);
          state_d  = (opcode_t'(bus.opcode) == OP_EONLY) ? LD_E : LD_AB;
        end
      end
      LD_AB:  state_d = LD_CD;
      LD_CD:  state_d = LD_E;
      LD_E:   state_d = SETTLE;
      SETTLE: begin
        state_d    = DONE;
        res_data_d = bus.alu_result;
      end
      DONE: begin
        if (bus.res_ready) begin
          state_d    = IDLE;
          op_count_d = op_count_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    op_ready_d  = (state_d == IDLE);
    res_valid_d = (state_d == DONE);

    case (state_d)
      LD_AB:   reg_en_d = 5'b00011;
      LD_CD:   reg_en_d = 5'b01100;
      LD_E:    reg_en_d = 5'b10000;
      default: reg_en_d = '0;
    endcase

    f_add_d  = 1'b0;
    f_load_d = 1'b0;
    if (state_d != IDLE) begin
      case (opcode_d)
        OP_ADDI:   f_add_d  = 1'b1;
        OP_LOADSW: f_load_d = 1'b1;
        OP_EONLY:  f_add_d  = 1'b1;
        default: begin
          f_add_d  = 1'b0;
          f_load_d = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs; synchronous active-low reset discards any pending result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      opcode_q    <= OP_MAC;
      op_ready_q  <= 1'b0;
      reg_en_q    <= '0;
      f_add_q     <= 1'b0;
      f_load_q    <= 1'b0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      op_ready_q  <= op_ready_d;
      reg_en_q    <= reg_en_d;
      f_add_q     <= f_add_d;
      f_load_q    <= f_load_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  assign bus.op_ready  = op_ready_q;
  assign bus.reg_en    = reg_en_q;
  assign bus.f_add     = f_add_q;
  assign bus.f_load    = f_load_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_valid = res_valid_q;
  assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_alu_v2_seq_ctrl.sv
// Directed bench for alu_v2_seq_ctrl: reset, MAC/EONLY sequencing, backpressure,
// opcode changes after accept, reset mid-sequence and op_count wrap.
module tb_alu_v2_seq_ctrl;

  localparam int unsigned BW = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_v2_seq_ctrl_if #(.BUS_WIDTH(BW)) bus ();

  alu_v2_seq_ctrl #(.BUS_WIDTH(BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ctl(input string tag, input logic [4:0] re, input logic fa, input logic fl,
                     input logic rdy, input logic rv);
    chk({tag, ".reg_en"},    {27'd0, bus.reg_en},    {27'd0, re});
    chk({tag, ".f_add"},     {31'd0, bus.f_add},     {31'd0, fa});
    chk({tag, ".f_load"},    {31'd0, bus.f_load},    {31'd0, fl});
    chk({tag, ".op_ready"},  {31'd0, bus.op_ready},  {31'd0, rdy});
    chk({tag, ".res_valid"}, {31'd0, bus.res_valid}, {31'd0, rv});
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    bus.op_valid   = 1'b0;
    bus.opcode     = 2'b00;
    bus.alu_result = 8'h00;
    bus.res_ready  = 1'b0;

    // Reset
    tick();
    tick();
    ctl("rst", 5'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.res_data", {24'd0, bus.res_data}, 32'h00);
    chk("rst.op_count", {24'd0, bus.op_count}, 32'h00);
    rst_n = 1'b1;
    tick();
    ctl("rel", 5'h00, 1'b0, 1'b0, 1'b1, 1'b0);

    // MAC, accepted in cycle 0
    bus.op_valid = 1'b1; bus.opcode = 2'b00; bus.res_ready = 1'b1;
    tick(); bus.op_valid = 1'b0;
    ctl("mac_c1", 5'h03, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); ctl("mac_c2", 5'h0C, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); ctl("mac_c3", 5'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); ctl("mac_c4", 5'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.alu_result = 8'h2A;
    tick(); ctl("mac_c5", 5'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("mac_c5.res_data", {24'd0, bus.res_data}, 32'h2A);
    chk("mac_c5.op_count", {24'd0, bus.op_count}, 32'd0);
    bus.alu_result = 8'h00;
    tick(); ctl("mac_c6", 5'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("mac_c6.res_data", {24'd0, bus.res_data}, 32'h2A);
    chk("mac_c6.op_count", {24'd0, bus.op_count}, 32'd1);

    // EONLY
    bus.op_valid = 1'b1; bus.opcode = 2'b11; bus.alu_result = 8'h7F;
    tick(); bus.op_valid = 1'b0;
    ctl("eonly_c1", 5'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); ctl("eonly_c2", 5'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); ctl("eonly_c3", 5'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("eonly_c3.res_data", {24'd0, bus.res_data}, 32'h7F);
    tick(); ctl("eonly_c4", 5'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("eonly_c4.op_count", {24'd0, bus.op_count}, 32'd2);

    // ADDI with opcode switched to LOADSW after accept, then backpressure in DONE
    bus.op_valid = 1'b1; bus.opcode = 2'b01; bus.res_ready = 1'b0; bus.alu_result = 8'h55;
    tick(); bus.opcode = 2'b10;
    ctl("bp_c1", 5'h03, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); ctl("bp_c2", 5'h0C, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); ctl("bp_c3", 5'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); ctl("bp_c4", 5'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      ctl("bp_hold", 5'h00, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("bp_hold.res_data", {24'd0, bus.res_data}, 32'h55);
      bus.alu_result = ~bus.alu_result;
      bus.opcode     = 2'(i);
      tick();
    end
    ctl("bp_last", 5'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("bp_last.res_data", {24'd0, bus.res_data}, 32'h55);
    bus.res_ready = 1'b1; bus.op_valid = 1'b0;
    tick(); ctl("bp_after", 5'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp_after.op_count", {24'd0, bus.op_count}, 32'd3);
    chk("bp_after.res_data", {24'd0, bus.res_data}, 32'h55);

    // Reset while in LD_CD
    bus.op_valid = 1'b1; bus.opcode = 2'b00;
    tick(); bus.op_valid = 1'b0;
    tick(); ctl("rcd_c2", 5'h0C, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick(); ctl("rcd_rst", 5'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rcd_rst.res_data", {24'd0, bus.res_data}, 32'h00);
    chk("rcd_rst.op_count", {24'd0, bus.op_count}, 32'd0);
    rst_n = 1'b1;
    tick(); ctl("rcd_rel", 5'h00, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset while in DONE with a pending result
    bus.op_valid = 1'b1; bus.opcode = 2'b11; bus.res_ready = 1'b0; bus.alu_result = 8'h99;
    tick(); bus.op_valid = 1'b0;
    tick();
    tick(); ctl("rdn_done", 5'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rdn_done.res_data", {24'd0, bus.res_data}, 32'h99);
    rst_n = 1'b0;
    tick(); ctl("rdn_rst", 5'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rdn_rst.res_data", {24'd0, bus.res_data}, 32'h00);
    chk("rdn_rst.op_count", {24'd0, bus.op_count}, 32'd0);
    rst_n = 1'b1;
    tick(); ctl("rdn_rel", 5'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rdn_rel.op_count", {24'd0, bus.op_count}, 32'd0);

    // 256 back-to-back LOADSW ops: op_count wraps to 0
    bus.op_valid = 1'b1; bus.opcode = 2'b10; bus.res_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      chk("wrap.op_ready", {31'd0, bus.op_ready}, 32'd1);
      chk("wrap.op_count", {24'd0, bus.op_count}, 32'(i));
      tick();
      for (int k = 1; k <= 5; k++) begin
        chk("wrap.f_load", {31'd0, bus.f_load}, 32'd1);
        chk("wrap.f_add",  {31'd0, bus.f_add},  32'd0);
        if (k == 5) chk("wrap.res_valid", {31'd0, bus.res_valid}, 32'd1);
        tick();
      end
    end
    bus.op_valid = 1'b0;
    chk("wrap.final_count", {24'd0, bus.op_count}, 32'd0);
    ctl("wrap_end", 5'h00, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_v2_seq_ctrl.md
ALU_V2_SEQ_CTRL -- requirements
Module: alu_v2_seq_ctrl

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 8, datapath width of the sequenced ALU.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port op_valid  input  1  operation request valid.
REQ-005 SHALL have port op_ready  output  1  controller can accept a request this cycle.
REQ-006 SHALL have port opcode  input  2  00=MAC, 01=ADDI, 10=LOADSW, 11=EONLY; sampled on accept.
REQ-007 SHALL have port reg_en  output  5  ALU register enables; [0..3] mult-stage a..d, [4] op_e register.
REQ-008 SHALL have port f_add  output  1  ALU add/immediate select.
REQ-009 SHALL have port f_load  output  1  ALU switch-load select.
REQ-010 SHALL have port alu_result  input  BUS_WIDTH  ALU result bus.
REQ-011 SHALL have port res_data  output  BUS_WIDTH  captured result.
REQ-012 SHALL have port res_valid  output  1  res_data valid.
REQ-013 SHALL have port res_ready  input  1  consumer accepts res_data.
REQ-014 SHALL have port op_count  output  8  count of completed (handed-off) operations.

Function
REQ-015 SHALL implement states IDLE, LD_AB, LD_CD, LD_E, SETTLE, DONE.
REQ-016 SHALL assert op_ready only in IDLE; accept = op_valid && op_ready.
REQ-017 On accept SHALL latch opcode; MAC/ADDI/LOADSW go to LD_AB, EONLY goes to LD_E.
REQ-018 SHALL drive reg_en=5'b00011 in LD_AB, 5'b01100 in LD_CD, 5'b10000 in LD_E, 5'b00000 in all other states.
REQ-019 SHALL advance LD_AB->LD_CD->LD_E->SETTLE->DONE unconditionally, one cycle each.
REQ-020 SHALL drive f_add/f_load from the latched opcode from the cycle after accept through DONE: MAC 0/0, ADDI 1/0, LOADSW 0/1, EONLY 1/0; both 0 in IDLE.
REQ-021 SHALL capture alu_result into res_data on the SETTLE->DONE transition and assert res_valid while in DONE.
REQ-022 SHALL hold res_data and res_valid stable in DONE until res_ready=1; res_data SHALL be unchanged outside that capture.
REQ-023 On res_valid && res_ready SHALL go to IDLE and increment op_count modulo 256 (255->0).
REQ-024 Latency: request accepted in cycle N -> res_valid first high in cycle N+5 (MAC/ADDI/LOADSW), N+3 (EONLY).
REQ-025 SHALL NOT accept a new request in the same cycle as a DONE hand-off; op_ready rises the cycle after.
REQ-026 opcode/op_valid changes while not in IDLE SHALL have no effect.

Reset
REQ-027 When rst_n=0 at a clock edge, SHALL enter IDLE regardless of current state, including mid-sequence and DONE with res_valid high.
REQ-028 Reset values: reg_en=0, f_add=0, f_load=0, res_valid=0, res_data=0, op_count=0, op_ready=0 during reset cycle, 1 on first cycle after release.
REQ-029 A result pending in DONE at reset SHALL be discarded and not counted.

Verification
REQ-030 MAC, op_valid=1 cycle 0, alu_result=8'h2A at SETTLE, res_ready=1 -> reg_en 03,0C,10 on cycles 1-3, res_valid cycle 5, res_data=8'h2A, op_count=1.
REQ-031 EONLY, f_add=1, alu_result=8'h7F -> reg_en=10 cycle 1 only, res_valid cycle 3, res_data=8'h7F.
REQ-032 Backpressure: res_ready=0 for 4 cycles in DONE while alu_result toggles -> res_data/res_valid stable, op_ready=0, op_valid ignored; handoff on res_ready=1, op_ready=1 next cycle.
REQ-033 Reset mid LD_CD and mid DONE -> next cycle IDLE, all outputs at reset values, op_count unchanged from 0/previous reset value 0.
REQ-034 256 back-to-back LOADSW ops with res_ready=1 -> op_count wraps to 0; f_load=1, f_add=0 throughout each op.
REQ-035 Opcode changed from ADDI to LOADSW in cycle after accept -> f_add/f_load remain 1/0 for the whole op.
